fa_nbit_seq: RTL and testbench
==============================

FA_NBIT_SEQ -- requirements
Module: fa_nbit_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and sum width in bits; legal values are 1 to 64.
REQ-002 SHALL have parameter DIGIT, default 2: bits added per clock; legal values are 1 to WIDTH, and WIDTH % DIGIT SHALL be 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin an addition.
REQ-006 SHALL have port a, input, WIDTH bits: operand A, unsigned.
REQ-007 SHALL have port b, input, WIDTH bits: operand B, unsigned.
REQ-008 SHALL have port ci, input, 1 bit: carry-in.
REQ-009 SHALL have port s, output, WIDTH bits: registered sum.
REQ-010 SHALL have port co, output, 1 bit: registered carry-out.
REQ-011 SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid new result.
REQ-013 SHALL have port ovf, output, 1 bit, present only under FA_NBIT_SEQ_OVF_EN: signed two's-complement overflow.

Function
REQ-014 SHALL compute {co,s} = a + b + ci, exactly equal to the (WIDTH+1)-bit sum.
REQ-015 SHALL implement states IDLE, RUN and DONE; N = WIDTH/DIGIT.
REQ-016 In IDLE or DONE, start=1 at an edge SHALL capture a, b and ci into internal registers, clear the chunk counter, and enter RUN.
REQ-017 In IDLE or DONE, start=0 at an edge SHALL enter or remain in IDLE.
REQ-018 In RUN, each edge SHALL add the next DIGIT-bit chunk, LSB chunk first, using the registered carry, then advance the counter.
REQ-019 After the Nth RUN edge the FSM SHALL enter DONE and load s and co with the full result on that same edge.
REQ-020 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-021 Latency: if start is sampled at edge k, done SHALL be high during the cycle after edge k+N, and for one cycle only.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the running operation.
REQ-023 start during the DONE cycle SHALL be accepted, giving back-to-back operations with one DONE cycle between them.
REQ-024 s, co and ovf SHALL change only on the DONE-entry edge and SHALL hold their values otherwise, including with no intermediate partial sums visible.
REQ-025 Changes on a, b or ci after the capture edge SHALL NOT affect the result.
REQ-026 DIGIT=WIDTH SHALL give N=1: one RUN cycle, with done two cycles after the start edge.

Reset
REQ-027 Asserting rst SHALL immediately force IDLE and set s=0, co=0, busy=0, done=0, ovf=0, and clear the counter and operand registers.
REQ-028 Reset during RUN SHALL abort the operation, with no done pulse and no partial result.
REQ-029 After rst deasserts, the first edge with start=1 SHALL begin a normal operation.

Configuration
REQ-030 Macro FA_NBIT_SEQ_OVF_EN defined: port ovf exists and SHALL be loaded at DONE-entry with (a[MSB]==b[MSB]) && (s[MSB]!=a[MSB]), using the captured operands.
REQ-031 Macro FA_NBIT_SEQ_OVF_EN undefined: no ovf port and no overflow logic; all other behaviour is identical.

Verification
REQ-032 WIDTH=8, DIGIT=2, a=0xFF, b=0x01, ci=0, start pulse -> busy high for 4 cycles, then done pulse with s=0x00, co=1.
REQ-033 WIDTH=8, DIGIT=2, OVF_EN defined, a=0x7F, b=0x01, ci=0 -> s=0x80, co=0, ovf=1; a=0x80, b=0x80, ci=1 -> s=0x01, co=1, ovf=1.
REQ-034 During RUN, apply start=1 with a=0x11 -> ignored, and the original result s=0x00, co=1 is still delivered.
REQ-035 Assert rst two cycles into RUN -> outputs are 0 at once, no done pulse, and the next start with a=0x12, b=0x34, ci=1 gives s=0x47, co=0.
REQ-036 WIDTH=8, DIGIT=8, a=0xA5, b=0x5A, ci=1 -> done two cycles after the start edge, with s=0x00, co=1.
REQ-037 Random operands with start held high continuously -> done every N+1 cycles, and every result matches a+b+ci.

Source files
------------

// File: rtl/fa_nbit_seq.sv
// rtl/fa_nbit_seq.sv - multi-cycle adder, DIGIT bits per clock, registered {co,s}
// Optional signed-overflow output ovf enabled by defining FA_NBIT_SEQ_OVF_EN.
module fa_nbit_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             busy,
`ifdef FA_NBIT_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             done
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               co_q, co_d;
`ifdef FA_NBIT_SEQ_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    logic [DIGIT:0]     chunk;
    logic [WIDTH-1:0]   sum_full;

    // Operands shift right each RUN cycle; each chunk sum enters psum from the top,
    // so after N cycles psum holds the whole sum aligned at bit 0.
    assign chunk    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
    assign sum_full = (psum_q >> DIGIT) | (WIDTH'(chunk[DIGIT-1:0]) << (WIDTH - DIGIT));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        psum_d  = psum_q;
        s_d     = s_q;
        co_d    = co_q;
`ifdef FA_NBIT_SEQ_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = ci;
                    cnt_d   = '0;
                    psum_d  = '0;
                    state_d = RUN;
`ifdef FA_NBIT_SEQ_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d    = a_q >> DIGIT;
                b_d    = b_q >> DIGIT;
                c_d    = chunk[DIGIT];
                psum_d = sum_full;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = DONE;
                    s_d     = sum_full;
                    co_d    = chunk[DIGIT];
`ifdef FA_NBIT_SEQ_OVF_EN
                    ovf_d   = (a_msb_q == b_msb_q) && (sum_full[WIDTH-1] != a_msb_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            psum_q  <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
`ifdef FA_NBIT_SEQ_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            psum_q  <= psum_d;
            s_q     <= s_d;
            co_q    <= co_d;
`ifdef FA_NBIT_SEQ_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign s    = s_q;
    assign co   = co_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
`ifdef FA_NBIT_SEQ_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_fa_nbit_seq.sv
// tb/tb_fa_nbit_seq.sv - randomized self-checking bench for fa_nbit_seq
module tb_fa_nbit_seq;

    localparam int W = 8;
    localparam int D = 2;
    localparam int N = W / D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic [W-1:0] s, s8;
    logic         co, busy, done, co8, busy8, done8;
`ifdef FA_NBIT_SEQ_OVF_EN
    logic         ovf, ovf8;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fa_nbit_seq #(.WIDTH(W), .DIGIT(D)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
        .s(s), .co(co), .busy(busy),
`ifdef FA_NBIT_SEQ_OVF_EN
        .ovf(ovf),
`endif
        .done(done)
    );

    fa_nbit_seq #(.WIDTH(W), .DIGIT(W)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
        .s(s8), .co(co8), .busy(busy8),
`ifdef FA_NBIT_SEQ_OVF_EN
        .ovf(ovf8),
`endif
        .done(done8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef FA_NBIT_SEQ_OVF_EN
    function automatic logic ovf_ref(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int v;
        v = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (v > 127) || (v < -128);
    endfunction
`endif

    // One start pulse; glitch_at >= 0 raises start with new operands mid-run.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci,
                          input int glitch_at);
        logic [W:0]   exp;
        logic [W-1:0] s_prev;
        logic         co_prev;
        int           lat;
        exp     = (W+1)'(ta) + (W+1)'(tb) + (W+1)'(tci);
        s_prev  = s;
        co_prev = co;
        a = ta; b = tb; ci = tci; start = 1'b1;
        tick();
        lat = 0;
        while (!done && lat < 4 * N) begin
            check("busy", 64'(busy), 64'd1);
            check("hold_s", 64'(s), 64'(s_prev));
            check("hold_co", 64'(co), 64'(co_prev));
            start = (lat == glitch_at);
            a = (lat == glitch_at) ? 8'h11 : W'($urandom);
            b = W'($urandom);
            ci = 1'($urandom);
            tick();
            lat++;
        end
        start = 1'b0;
        check("latency", 64'(lat), 64'(N));
        check("busy_in_done", 64'(busy), 64'd0);
        check("sum", 64'(s), 64'(exp[W-1:0]));
        check("co", 64'(co), 64'(exp[W]));
`ifdef FA_NBIT_SEQ_OVF_EN
        check("ovf", 64'(ovf), 64'(ovf_ref(ta, tb, tci)));
`endif
        tick();
        check("done_one_cycle", 64'(done), 64'd0);
        check("sum_held", 64'(s), 64'(exp[W-1:0]));
    endtask

    logic [W-1:0] oa, ob;
    logic         oc;
    logic [W:0]   oexp;

    initial begin
        #12;
        check("rst_s", 64'(s), 64'd0);
        check("rst_co", 64'(co), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
`ifdef FA_NBIT_SEQ_OVF_EN
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_op(8'hFF, 8'h01, 1'b0, -1);
`ifdef FA_NBIT_SEQ_OVF_EN
        run_op(8'h7F, 8'h01, 1'b0, -1);
        check("ovf_7f", 64'(ovf), 64'd1);
        run_op(8'h80, 8'h80, 1'b1, -1);
        check("ovf_80", 64'(ovf), 64'd1);
`endif
        run_op(8'hFF, 8'h01, 1'b0, 1);

        // Abort two cycles into RUN
        a = 8'h3C; b = 8'h5A; ci = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("abort_s", 64'(s), 64'd0);
        check("abort_co", 64'(co), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            tick();
            check("abort_no_done", 64'(done), 64'd0);
        end
        run_op(8'h12, 8'h34, 1'b1, -1);

        // DIGIT == WIDTH: a single RUN cycle
        a = 8'hA5; b = 8'h5A; ci = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("d8_busy", 64'(busy8), 64'd1);
        check("d8_early", 64'(done8), 64'd0);
        tick();
        check("d8_done", 64'(done8), 64'd1);
        check("d8_s", 64'(s8), 64'd0);
        check("d8_co", 64'(co8), 64'd1);
        repeat (N + 2) tick();

        for (int i = 0; i < 16; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, N - 1)) : -1);

        // start held high: a new operation every N+1 cycles
        oa = W'($urandom); ob = W'($urandom); oc = 1'($urandom);
        a = oa; b = ob; ci = oc; start = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            oexp = (W+1)'(oa) + (W+1)'(ob) + (W+1)'(oc);
            for (int j = 0; j < N; j++) begin
                check("b2b_busy", 64'(busy), 64'd1);
                check("b2b_no_done", 64'(done), 64'd0);
                a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
                tick();
            end
            check("b2b_done", 64'(done), 64'd1);
            check("b2b_sum", 64'(s), 64'(oexp[W-1:0]));
            check("b2b_co", 64'(co), 64'(oexp[W]));
`ifdef FA_NBIT_SEQ_OVF_EN
            check("b2b_ovf", 64'(ovf), 64'(ovf_ref(oa, ob, oc)));
`endif
            oa = W'($urandom); ob = W'($urandom); oc = 1'($urandom);
            a = oa; b = ob; ci = oc;
            tick();
        end
        start = 1'b0;
        repeat (N + 2) tick();
        check("final_idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
